// File: rtl/simple_fifo_sv.sv
// Synchronous FIFO with a registered read port, count-decoded status flags
// and sticky overflow/underflow error flags.
module simple_fifo_sv #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [DW-1:0]              d_in,
   input  logic                       rd_en,
   output logic [DW-1:0]              d_out,
   output logic                       d_valid,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [DW-1:0] d_out_q, d_out_d;
   logic          d_valid_q, d_valid_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic do_wr;
   logic do_rd;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   // A read on a full FIFO frees a slot in the same cycle, so the write is taken.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | rd_en);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      d_out_d     = d_out_q;
      d_valid_d   = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         d_out_d   = mem[rd_ptr_q];
         d_valid_d = 1'b1;
      end

      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (wr_en && full && !rd_en) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         d_out_q     <= '0;
         d_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         d_out_q     <= d_out_d;
         d_valid_q   <= d_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately not cleared by reset; the pointers make it unreachable.
   always_ff @(posedge clk) begin
      if (!reset && do_wr) begin
         mem[wr_ptr_q] <= d_in;
      end
   end

   assign d_out     = d_out_q;
   assign d_valid   = d_valid_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
